dram_dp_param: RTL

//   Parametrised dual-port register RAM, next generation of the 16x8 local register store.

---
 rtl/dram_dp_param.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dram_dp_param.sv
// -----------------------------------------------------------------------------
// dram_dp_param
//   Parametrised dual-port register RAM used as shared scratch storage between
//   two independent bus agents. Both ports read and write the same
//   DEPTH x DATA_W register array. The array offers:
//     - deterministic handling of writes from both ports to the same address
//       (port A wins, o_coll pulses the next cycle);
//     - write-first forwarding when one port writes and the other reads the
//       same address in the same cycle;
//     - one-cycle read-valid strobes;
//     - a sequential bulk-clear engine that zeroes one entry per cycle and
//       reports o_busy while it runs.
//
// Ports
//   i_ck, i_rst            clock (rising edge), asynchronous active-high reset
//   i_csn_x                port x chip select, 0 = access this cycle
//   i_rw_x                 port x direction, 0 = write, 1 = read
//   i_addr_x, i_data_x     port x address / write data
//   o_data_x, o_vld_x      port x registered read data / one-cycle valid pulse
//   i_clr                  start bulk clear (sampled in IDLE only)
//   o_busy                 clear engine running, port accesses ignored
//   o_coll                 registered pulse: both ports wrote the same address
// -----------------------------------------------------------------------------
module dram_dp_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              i_ck,
  input  logic              i_rst,
  input  logic              i_csn_a,
  input  logic              i_rw_a,
  input  logic [ADDR_W-1:0] i_addr_a,
  input  logic [DATA_W-1:0] i_data_a,
  output logic [DATA_W-1:0] o_data_a,
  output logic              o_vld_a,
  input  logic              i_csn_b,
  input  logic              i_rw_b,
  input  logic [ADDR_W-1:0] i_addr_b,
  input  logic [DATA_W-1:0] i_data_b,
  output logic [DATA_W-1:0] o_data_b,
  output logic              o_vld_b,
  input  logic              i_clr,
  output logic              o_busy,
  output logic              o_coll
);

  localparam int DEPTH = 2 ** ADDR_W;
  // Index of the final entry cleared; the engine returns to IDLE after it.
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DATA_W-1:0]   data_a_q, data_a_d;
  logic [DATA_W-1:0]   data_b_q, data_b_d;
  logic                vld_a_q, vld_a_d;
  logic                vld_b_q, vld_b_d;
  logic                coll_q, coll_d;

  // Port decode. Accesses only count while the clear engine is idle.
  logic idle;
  logic wr_a, rd_a, wr_b, rd_b;
  logic same_addr;

  assign idle      = (state_q == ST_IDLE);
  assign wr_a      = idle && !i_csn_a && !i_rw_a;
  assign rd_a      = idle && !i_csn_a &&  i_rw_a;
  assign wr_b      = idle && !i_csn_b && !i_rw_b;
  assign rd_b      = idle && !i_csn_b &&  i_rw_b;
  assign same_addr = (i_addr_a == i_addr_b);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    vld_a_d  = 1'b0;
    vld_b_d  = 1'b0;
    coll_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Reads see the value being written by the other port this cycle
        // (write-first); otherwise the stored value before this edge.
        if (rd_a) begin
          vld_a_d  = 1'b1;
          data_a_d = (wr_b && same_addr) ? i_data_b : mem_q[i_addr_a];
        end
        if (rd_b) begin
          vld_b_d  = 1'b1;
          data_b_d = (wr_a && same_addr) ? i_data_a : mem_q[i_addr_b];
        end

        coll_d = wr_a && wr_b && same_addr;

        // On a same-address double write, B's data is dropped.
        if (wr_b && !(wr_a && same_addr)) begin
          mem_d[i_addr_b] = i_data_b;
        end
        if (wr_a) begin
          mem_d[i_addr_a] = i_data_a;
        end

        // Accesses in the cycle i_clr is sampled still complete above.
        if (i_clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end

      ST_CLEAR: begin
        mem_d[cnt_q[ADDR_W-1:0]] = '0;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_ck or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      vld_a_q  <= 1'b0;
      vld_b_q  <= 1'b0;
      coll_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      vld_a_q  <= vld_a_d;
      vld_b_q  <= vld_b_d;
      coll_q   <= coll_d;
      mem_q    <= mem_d;
    end
  end

  assign o_data_a = data_a_q;
  assign o_vld_a  = vld_a_q;
  assign o_data_b = data_b_q;
  assign o_vld_b  = vld_b_q;
  assign o_coll   = coll_q;
  assign o_busy   = (state_q == ST_CLEAR);

endmodule
